// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: FSM encoding, error causes and
// fixed instruction-memory constants.
package boot_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StLenHi,
      StLenLo,
      StData,
      StCheck,
      StDone,
      StErr
   } boot_state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_CHK     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'h55;
   localparam logic [31:0] IMEM_BASE         = 32'h0000_0000;

endpackage

// File: rtl/byte_to_word_asm.sv
// Packs an MSB-first byte stream into 32-bit words; word_valid pulses the cycle
// after the fourth byte, while word still holds the completed value.
module byte_to_word_asm
   import boot_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_last_byte,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [31:0] shift_q;
   logic [1:0]  cnt_q;
   logic        valid_q;

   assign word_last_byte = byte_valid && (cnt_q == 2'd3);
   assign word_valid     = valid_q;
   assign word           = shift_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         shift_q <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= word_last_byte;
         if (byte_valid) begin
            shift_q <= {shift_q[23:0], byte_data};
            cnt_q   <= cnt_q + 2'd1;
         end
      end
   end

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a framed program image from the UART into instruction RAM and keeps the
// CPU in reset until a complete, checksum-valid image has been written.
module imem_uart_loader
   import boot_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned MAX_WORDS      = 256,
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code
);

   localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   boot_state_e      state_q, state_d;
   logic [1:0]       err_code_q, err_code_d;
   logic [7:0]       len_hi_q, len_hi_d;
   logic [15:0]      len_q, len_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       chk_q, chk_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   logic        asm_clr, asm_valid, asm_last, asm_word_valid;
   logic [31:0] asm_word;
   logic        timed, tmo_hit, last_word;
   logic [15:0] len_rx;

   byte_to_word_asm u_asm (
      .clk            (clk),
      .reset          (reset),
      .clr            (asm_clr),
      .byte_valid     (asm_valid),
      .byte_data      (rx_data),
      .word_last_byte (asm_last),
      .word_valid     (asm_word_valid),
      .word           (asm_word)
   );

   assign timed     = state_q inside {StLenHi, StLenLo, StData, StCheck};
   // A byte arriving on the limit cycle wins over the timeout.
   assign tmo_hit   = timed && !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
   assign len_rx    = {len_hi_q, rx_data};
   assign last_word = (16'(idx_q) + 16'd1) == len_q;

   always_comb begin
      state_d    = state_q;
      err_code_d = err_code_q;
      len_hi_d   = len_hi_q;
      len_d      = len_q;
      idx_d      = idx_q;
      chk_d      = chk_q;
      tmo_d      = (rx_valid || !timed) ? '0 : tmo_q + TMO_W'(1);
      asm_clr    = 1'b0;
      asm_valid  = 1'b0;

      if (asm_word_valid) begin
         idx_d = idx_q + IDX_W'(1);
      end

      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               state_d    = StSync;
               err_code_d = ERR_NONE;
            end
         end
         StSync: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
               state_d = StLenHi;
            end
         end
         StLenHi: begin
            if (rx_valid) begin
               len_hi_d = rx_data;
               state_d  = StLenLo;
            end
         end
         StLenLo: begin
            if (rx_valid) begin
               len_d = len_rx;
               if (len_rx == 16'd0 || len_rx > 16'(MAX_WORDS)) begin
                  state_d    = StErr;
                  err_code_d = ERR_LEN;
               end else begin
                  state_d = StData;
                  idx_d   = '0;
                  chk_d   = '0;
                  asm_clr = 1'b1;
               end
            end
         end
         StData: begin
            if (rx_valid) begin
               asm_valid = 1'b1;
               chk_d     = chk_q ^ rx_data;
               // The final word's write lands in the first CHECK cycle, so a
               // back-to-back CHK byte is never mistaken for payload.
               if (asm_last && last_word) begin
                  state_d = StCheck;
               end
            end
         end
         StCheck: begin
            if (rx_valid) begin
               if (rx_data == chk_q) begin
                  state_d = StDone;
               end else begin
                  state_d    = StErr;
                  err_code_d = ERR_CHK;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (tmo_hit) begin
         state_d    = StErr;
         err_code_d = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         err_code_q <= ERR_NONE;
         len_hi_q   <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         chk_q      <= '0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         err_code_q <= err_code_d;
         len_hi_q   <= len_hi_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         chk_q      <= chk_d;
         tmo_q      <= tmo_d;
      end
   end

   assign imem_we    = asm_word_valid;
   assign imem_addr  = IMEM_BASE | 32'({idx_q[ADDR_WIDTH-1:0], 2'b00});
   assign imem_wdata = asm_word;
   assign busy       = state_q inside {StSync, StLenHi, StLenLo, StData, StCheck};
   assign cpu_hold   = busy || (state_q == StErr);
   assign done       = (state_q == StDone);
   assign error      = (state_q == StErr);
   assign err_code   = err_code_q;

endmodule
